// File: rtl/thc_pkg.sv
// thc_pkg: shared Hamming(38,32) layout for the encoder and the matching decoder.
//   DATA_W / PAR_W / CODE_W : fixed widths (32 data, 6 parity, 38 code bits)
//   data_pos(i)             : codeword position (1..38) of data bit i
//   is_par_pos(p)           : 1 when position p holds a parity bit (power of two)
//   hamming_encode(data)    : 38-bit codeword, data_out[p-1] holds position p
//   hamming_syndrome(code)  : 6-bit syndrome, equals the flipped position on a single error
package thc_pkg;

  localparam int DATA_W = 32;
  localparam int PAR_W  = 6;
  localparam int CODE_W = 38;

  // Data fills the non-power-of-two positions in ascending order, so each run of
  // data bits between two parity slots is shifted by the number of parity slots below it.
  function automatic logic [5:0] data_pos(input logic [4:0] i);
    logic [5:0] pos;
    if (i == 5'd0) begin
      pos = 6'd3;
    end else if (i <= 5'd3) begin
      pos = {1'b0, i} + 6'd4;
    end else if (i <= 5'd10) begin
      pos = {1'b0, i} + 6'd5;
    end else if (i <= 5'd25) begin
      pos = {1'b0, i} + 6'd6;
    end else begin
      pos = {1'b0, i} + 6'd7;
    end
    return pos;
  endfunction

  function automatic logic is_par_pos(input logic [5:0] p);
    return (p != 6'd0) && ((p & (p - 6'd1)) == 6'd0);
  endfunction

  function automatic logic [CODE_W-1:0] hamming_encode(input logic [DATA_W-1:0] data);
    logic [CODE_W-1:0] code;
    logic              par;
    code = '0;
    for (int i = 0; i < DATA_W; i++) begin
      code[data_pos(5'(i)) - 6'd1] = data[i];
    end
    // P_k covers every data position whose index has bit k set; parity slots are
    // still zero here but are skipped explicitly so the intent is plain.
    for (int k = 0; k < PAR_W; k++) begin
      par = 1'b0;
      for (int j = 1; j <= CODE_W; j++) begin
        if (j[k] && !is_par_pos(6'(j))) begin
          par = par ^ code[j-1];
        end
      end
      code[(32'sd1 << k) - 32'sd1] = par;
    end
    return code;
  endfunction

  // Syndrome over the full codeword, parity bits included: zero for a clean word,
  // the position of the flipped bit for a single-bit error.
  function automatic logic [PAR_W-1:0] hamming_syndrome(input logic [CODE_W-1:0] code);
    logic [PAR_W-1:0] syn;
    syn = '0;
    for (int k = 0; k < PAR_W; k++) begin
      for (int j = 1; j <= CODE_W; j++) begin
        if (j[k]) begin
          syn[k] = syn[k] ^ code[j-1];
        end
      end
    end
    return syn;
  endfunction

endpackage

// File: rtl/thc_enc_comb.sv
// thc_enc_comb: purely combinational Hamming(38,32) encoder.
//   data_in  [31:0] : data word
//   code_out [37:0] : codeword, code_out[p-1] holds position p
module thc_enc_comb
  import thc_pkg::*;
(
  input  logic [DATA_W-1:0] data_in,
  output logic [CODE_W-1:0] code_out
);

  // Codeword is a pure function of the data word.
  always_comb begin
    code_out = hamming_encode(data_in);
  end

endmodule

// File: rtl/thc.sv
// thc: registered Hamming(38,32) SEC encoder, one-cycle latency, no backpressure.
//   clk       : single clock, rising edge
//   rst       : asynchronous active-high reset
//   data_in   : 32-bit data word
//   in_valid  : data_in valid this cycle
//   data_out  : registered 38-bit codeword (holds when no new word arrives)
//   out_valid : data_out carries a new codeword this cycle
module thc
  import thc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              in_valid,
  output logic [CODE_W-1:0] data_out,
  output logic              out_valid
);

  logic [CODE_W-1:0] w_code;
  logic [CODE_W-1:0] r_data;
  logic              r_valid;

  thc_enc_comb u_enc (
    .data_in  (data_in),
    .code_out (w_code)
  );

  // Output register: capture only on valid so an idle (possibly X) data_in never reaches data_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= {CODE_W{1'b0}};
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_data <= w_code;
      end else begin
        r_data <= r_data;
      end
    end
  end

  assign data_out  = r_data;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_thc.sv
module tb_thc;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in;
  logic        in_valid;
  logic [37:0] data_out;
  logic        out_valid;

  int n_vec = 0;
  int n_err = 0;

  thc dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .in_valid  (in_valid),
    .data_out  (data_out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  // Independent model: data fills non-power-of-two slots in order, then parity
  // bits are set to the XOR of the positions of all set data bits.
  function automatic logic [5:0] model_syndrome(input logic [37:0] c);
    logic [5:0] s;
    s = 6'd0;
    for (int p = 1; p <= 38; p++) begin
      if (c[p-1]) s = s ^ 6'(p);
    end
    return s;
  endfunction

  function automatic logic [37:0] model_encode(input logic [31:0] d);
    logic [37:0] c;
    logic [5:0]  s;
    int          di;
    c  = 38'd0;
    di = 0;
    for (int p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p-1] = d[di];
        di++;
      end
    end
    s = model_syndrome(c);
    for (int k = 0; k < 6; k++) c[(1 << k) - 1] = s[k];
    return c;
  endfunction

  function automatic logic [31:0] model_strip(input logic [37:0] c);
    logic [31:0] d;
    int          di;
    d  = 32'd0;
    di = 0;
    for (int p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[di] = c[p-1];
        di++;
      end
    end
    return d;
  endfunction

  // Present one input at the falling edge, then step to just after the next rising edge.
  task automatic drive(input logic v, input logic [31:0] d);
    @(negedge clk);
    in_valid = v;
    data_in  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst      = 1'b1;
    in_valid = 1'b0;
    data_in  = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (data_out !== 38'h0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: data_out=%h out_valid=%b expected 0/0", data_out, out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 32'h12345678);
      n_vec++;
      if (data_out !== 38'h0 || out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL idle_after_reset: data_out=%h out_valid=%b expected 0/0", data_out, out_valid);
      end
    end
    drive(1'b1, 32'h1);
    n_vec++;
    if (data_out !== 38'h7 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL pre_async_word: data_out=%h out_valid=%b expected 0000000007/1", data_out, out_valid);
    end
    // Mid-cycle assertion: no clock edge between rst rising and the check.
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if (data_out !== 38'h0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: data_out=%h out_valid=%b expected 0/0", data_out, out_valid);
    end
    drive(1'b1, 32'hFFFFFFFF);
    n_vec++;
    if (data_out !== 38'h0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_held: data_out=%h out_valid=%b expected 0/0", data_out, out_valid);
    end
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    if (data_out !== 38'h0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: data_out=%h out_valid=%b expected 0/0", data_out, out_valid);
    end
    drive(1'b1, 32'h2);
    n_vec++;
    if (data_out !== 38'h19 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL first_after_reset: data_out=%h out_valid=%b expected 0000000019/1", data_out, out_valid);
    end
  endtask

  task automatic test_directed;
    logic [31:0] din [5];
    logic [37:0] exp [5];
    din = '{32'h1, 32'h2, 32'h80000000, 32'h0, 32'hFFFFFFFF};
    exp = '{38'h7, 38'h19, 38'h208000000A, 38'h0, 38'h3F7FFFFFF4};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, din[i]);
      n_vec++;
      if (data_out !== exp[i] || out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL directed[%0d] din=%h: data_out=%h out_valid=%b expected %h/1",
                 i, din[i], data_out, out_valid, exp[i]);
      end
    end
  endtask

  task automatic test_mixed;
    logic [37:0] exp;
    exp = model_encode(32'hCAFE3475);
    drive(1'b1, 32'hCAFE3475);
    n_vec++;
    if (data_out !== exp || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL mixed_code: data_out=%h out_valid=%b expected %h/1", data_out, out_valid, exp);
    end
    n_vec++;
    if (model_strip(data_out) !== 32'hCAFE3475) begin
      n_err++;
      $display("FAIL mixed_strip: got %h expected cafe3475", model_strip(data_out));
    end
    n_vec++;
    if (model_syndrome(data_out) !== 6'd0) begin
      n_err++;
      $display("FAIL mixed_syndrome: got %0d expected 0", model_syndrome(data_out));
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] w;
    logic [37:0] exp;
    exp = 38'h0;
    for (int i = 0; i < 100; i++) begin
      w   = $urandom;
      exp = model_encode(w);
      drive(1'b1, w);
      n_vec++;
      if (data_out !== exp || out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL b2b[%0d] din=%h: data_out=%h out_valid=%b expected %h/1",
                 i, w, data_out, out_valid, exp);
      end
    end
    drive(1'b0, 32'hxxxxxxxx);
    n_vec++;
    if (data_out !== exp || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL hold_x: data_out=%h out_valid=%b expected %h/0", data_out, out_valid, exp);
    end
    drive(1'b0, $urandom);
    n_vec++;
    if (data_out !== exp || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL hold_idle: data_out=%h out_valid=%b expected %h/0", data_out, out_valid, exp);
    end
  endtask

  task automatic test_error_coverage;
    logic [31:0] w;
    logic [37:0] c;
    logic [37:0] f;
    logic [5:0]  s;
    for (int n = 0; n < 4; n++) begin
      w = $urandom;
      drive(1'b1, w);
      c = data_out;
      n_vec++;
      if (c !== model_encode(w)) begin
        n_err++;
        $display("FAIL errcov_code[%0d] din=%h: data_out=%h expected %h", n, w, c, model_encode(w));
      end
      for (int b = 0; b < 38; b++) begin
        f = c ^ (38'd1 << b);
        s = model_syndrome(f);
        n_vec++;
        if (s !== 6'(b + 1)) begin
          n_err++;
          $display("FAIL errcov_syn din=%h bit=%0d: syndrome=%0d expected %0d", w, b, s, b + 1);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mixed();
    test_back_to_back();
    test_error_coverage();
    drive(1'b0, 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
